// File: rtl/controle_multiciclo.sv
// Main control FSM for a multi-cycle MIPS datapath: drives mux selects and write
// enables from the current state, waits on the memory handshake, and counts retired instructions.
module controle_multiciclo (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic [1:0]  pc_source,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [3:0]  estado,
  output logic        retire,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] instret_reg;

  // Strobes before reset gating; reset must silence them even before the state clears.
  logic pc_en_raw, mem_read_raw, mem_write_raw, ir_write_raw;
  logic reg_write_raw, retire_raw, illegal_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_reg <= '0;
    end else if (retire_raw) begin
      instret_reg <= instret_reg + 32'd1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_en_raw     = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    retire_raw    = 1'b0;
    illegal_raw   = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state_reg)
      FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_en_raw    = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:    state_next = MEM_ADDR;
          OP_R:            state_next = EXECUTE;
          OP_BEQ, OP_BNE:  state_next = BRANCH;
          OP_J:            state_next = JUMP;
          OP_ADDI:         state_next = ADDI_EXEC;
          default: begin
            illegal_raw = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read_raw = 1'b1;
        iord         = 1'b1;
        if (mem_ready) state_next = MEM_WB;
      end
      MEM_WB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_next    = FETCH;
      end
      MEM_WRITE: begin
        mem_write_raw = 1'b1;
        iord          = 1'b1;
        retire_raw    = mem_ready;
        if (mem_ready) state_next = FETCH;
      end
      EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = ALU_WB;
      end
      ALU_WB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_next    = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_source  = 2'b01;
        pc_en_raw  = (opcode == OP_BNE) ? ~zero : zero;
        retire_raw = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        pc_source  = 2'b10;
        pc_en_raw  = 1'b1;
        retire_raw = 1'b1;
        state_next = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
        state_next    = FETCH;
      end
      default: begin
        illegal_raw = 1'b1;
        state_next  = FETCH;
      end
    endcase
  end

  assign pc_en     = pc_en_raw     & ~reset;
  assign mem_read  = mem_read_raw  & ~reset;
  assign mem_write = mem_write_raw & ~reset;
  assign ir_write  = ir_write_raw  & ~reset;
  assign reg_write = reg_write_raw & ~reset;
  assign retire    = retire_raw    & ~reset;
  assign illegal   = illegal_raw   & ~reset;
  assign estado    = state_reg;
  assign instret   = instret_reg;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: walks each instruction class through the
// FSM with scripted memory stalls and compares state sequences and strobes with hand values.
module tb_controle_multiciclo;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en;
  logic [1:0]  pc_source;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [3:0]  estado;
  logic        retire;
  logic        illegal;
  logic [31:0] instret;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_instret = '0;

  controle_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .estado(estado), .retire(retire),
    .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one instruction from FETCH back to FETCH. fw/mw are the number of
  // mem_ready=0 cycles injected in FETCH and in MEM_READ/MEM_WRITE.
  // snap captures {mem_write, reg_dst, mem_to_reg, reg_write, pc_en, pc_source} at retire.
  task automatic run(input string name, input logic [5:0] op, input logic z,
                     input int fw, input int mw, input int exp_cycles,
                     input logic [63:0] exp_seq, input int exp_ret, input int exp_ill,
                     input logic [6:0] exp_snap);
    int          cycles = 0;
    int          ret = 0;
    int          ill = 0;
    int          irw = 0;
    bit          left = 0;
    logic [63:0] seq = '0;
    logic [6:0]  snap = '0;
    while (cycles < 40) begin
      opcode    = op;
      zero      = z;
      mem_ready = 1'b1;
      if (estado == 4'd0 && fw > 0) begin
        mem_ready = 1'b0;
        fw--;
      end else if ((estado == 4'd3 || estado == 4'd5) && mw > 0) begin
        mem_ready = 1'b0;
        mw--;
      end
      #1;
      seq = {seq[59:0], estado};
      cycles++;
      if (estado != 4'd0) left = 1;
      if (ir_write) irw++;
      if (illegal) ill++;
      if (retire) begin
        ret++;
        snap = {mem_write, reg_dst, mem_to_reg, reg_write, pc_en, pc_source};
      end
      @(negedge clk);
      if (left && estado == 4'd0) break;
    end
    check({name, "_done"}, 64'(left && estado == 4'd0), 64'd1);
    check({name, "_cycles"}, 64'(cycles), 64'(exp_cycles));
    check({name, "_seq"}, seq, exp_seq);
    check({name, "_retire"}, 64'(ret), 64'(exp_ret));
    check({name, "_illegal"}, 64'(ill), 64'(exp_ill));
    check({name, "_irwrite"}, 64'(irw), 64'd1);
    check({name, "_snap"}, 64'(snap), 64'(exp_snap));
    exp_instret = exp_instret + 32'(exp_ret);
    check({name, "_instret"}, 64'(instret), 64'(exp_instret));
    $display("instr %-8s op=%b cycles=%0d seq=%h instret=%0d", name, op, cycles, seq, instret);
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_estado", 64'(estado), 64'd0);
    check("rst_instret", 64'(instret), 64'd0);
    check("rst_enables", 64'({pc_en, ir_write, mem_read, mem_write, reg_write, retire, illegal}), 64'd0);
    check("rst_alu_src_b", 64'(alu_src_b), 64'b01);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_mem_read", 64'(mem_read), 64'd1);
    check("post_rst_estado", 64'(estado), 64'd0);
    $display("reset released, estado=%0d instret=%0d", estado, instret);

    run("rtype",  6'b000000, 1'b0, 0, 0, 4,  64'h0167,       1, 0, 7'b0101000);
    run("lw",     6'b100011, 1'b0, 2, 3, 10, 64'h0001233334, 1, 0, 7'b0011000);
    run("sw",     6'b101011, 1'b0, 0, 0, 4,  64'h0125,       1, 0, 7'b1000000);
    run("sw_wait",6'b101011, 1'b0, 0, 1, 5,  64'h01255,      1, 0, 7'b1000000);
    run("addi",   6'b001000, 1'b0, 0, 0, 4,  64'h01AB,       1, 0, 7'b0001000);
    run("beq_z1", 6'b000100, 1'b1, 0, 0, 3,  64'h018,        1, 0, 7'b0000101);
    run("beq_z0", 6'b000100, 1'b0, 0, 0, 3,  64'h018,        1, 0, 7'b0000001);
    run("bne_z0", 6'b000101, 1'b0, 0, 0, 3,  64'h018,        1, 0, 7'b0000101);
    run("bne_z1", 6'b000101, 1'b1, 0, 0, 3,  64'h018,        1, 0, 7'b0000001);
    run("j",      6'b000010, 1'b0, 0, 0, 3,  64'h019,        1, 0, 7'b0000110);
    run("illegal",6'b111111, 1'b0, 0, 0, 2,  64'h01,         0, 1, 7'b0000000);

    // Reset in the middle of a stalled store: no retire, outputs clear at once.
    opcode = 6'b101011;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("swrst_in_memwrite", 64'(estado), 64'd5);
    check("swrst_mem_write", 64'(mem_write), 64'd1);
    @(negedge clk);
    #1;
    check("swrst_waiting", 64'({estado, retire}), 64'({4'd5, 1'b0}));
    reset = 1'b1;
    #1;
    check("swrst_estado", 64'(estado), 64'd0);
    check("swrst_mem_write_off", 64'(mem_write), 64'd0);
    check("swrst_retire_off", 64'(retire), 64'd0);
    check("swrst_instret_zero", 64'(instret), 64'd0);
    exp_instret = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("swrst_after_estado", 64'(estado), 64'd0);
    $display("reset during sw wait, estado=%0d instret=%0d", estado, instret);

    // Preload the counter at its top value while FETCH stalls, then retire a jump.
    mem_ready = 1'b0;
    force dut.instret_reg = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.instret_reg;
    #1;
    check("wrap_preload", 64'(instret), 64'hFFFFFFFF);
    check("wrap_fetch_stall", 64'({estado, ir_write, pc_en}), 64'd0);
    exp_instret = 32'hFFFFFFFF;
    @(negedge clk);
    run("j_wrap", 6'b000010, 1'b0, 0, 0, 3, 64'h019, 1, 0, 7'b0000110);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
